// File: rtl/execute_bru_bco_ctrl.sv
// execute_bru_bco_ctrl
//   Sits between the branch unit's override (BCO) outputs and two shared
//   consumers: the front-end redirect path and the single branch-predictor
//   update port. Each accepted override produces a registered one-cycle
//   redirect pulse. Its predictor update, with the new saturated 2-bit
//   pattern already computed, is queued in a small FIFO. The FIFO drains to
//   the predictor through a valid/ready handshake.
//
//   Optional feature macro: BRU_BCO_COALESCE_EN
//     When this macro is defined, an override whose PC matches the newest
//     queued entry overwrites that entry in place instead of taking a new slot.
//
// Parameters
//   DEPTH   FIFO entries (power of 2, >= 2)
//   ADDR_W  log2(DEPTH)
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   i_flush                    drop queued updates and any pending redirect
//   i_bco_valid/pc/oldpattern/taken/target   override from the branch unit
//   o_redirect_valid/pc        one-cycle front-end redirect
//   o_upd_valid/pc/pattern/taken/target      head of the update queue
//   i_upd_ready                predictor accepts the head this cycle
//   o_full, o_empty            queue occupancy flags
//   o_drop                     pulse: override lost because the queue was full
module execute_bru_bco_ctrl #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_flush,
  input  logic        i_bco_valid,
  input  logic [31:0] i_bco_pc,
  input  logic [1:0]  i_bco_oldpattern,
  input  logic        i_bco_taken,
  input  logic [31:0] i_bco_target,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  output logic        o_upd_valid,
  output logic [31:0] o_upd_pc,
  output logic [1:0]  o_upd_pattern,
  output logic        o_upd_taken,
  output logic [31:0] o_upd_target,
  input  logic        i_upd_ready,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_drop
);

  logic [31:0]       mem_pc     [DEPTH];
  logic [1:0]        mem_pat    [DEPTH];
  logic              mem_taken  [DEPTH];
  logic [31:0]       mem_target [DEPTH];

  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count;

  logic              bco_ok;
  logic              pop;
  logic              push;
  logic              coalesce;
  logic              drop_next;
  logic [1:0]        new_pat;

  function automatic logic [1:0] sat_pattern(input logic [1:0] old, input logic taken);
    if (taken) sat_pattern = (old == 2'd3) ? 2'd3 : old + 2'd1;
    else       sat_pattern = (old == 2'd0) ? 2'd0 : old - 2'd1;
  endfunction

  assign o_full  = (count == (ADDR_W+1)'(DEPTH));
  assign o_empty = (count == '0);
  assign bco_ok  = i_bco_valid & ~i_flush;
  assign pop     = ~o_empty & i_upd_ready;
  assign new_pat = sat_pattern(i_bco_oldpattern, i_bco_taken);

`ifdef BRU_BCO_COALESCE_EN
  logic [ADDR_W-1:0] newest;
  assign newest = wr_ptr - ADDR_W'(1);
  // A lone head that is leaving this cycle cannot be overwritten; the
  // predictor already took it, so the override must get a fresh slot.
  assign coalesce = bco_ok & ~o_empty & (mem_pc[newest] == i_bco_pc)
                    & ~((count == (ADDR_W+1)'(1)) & pop);
`else
  assign coalesce = 1'b0;
`endif

  assign push      = bco_ok & ~coalesce & (~o_full | pop);
  assign drop_next = bco_ok & ~coalesce & o_full & ~pop;

  // Head data is gated so the update port reads all-zero whenever nothing is queued.
  assign o_upd_valid   = ~o_empty;
  assign o_upd_pc      = o_empty ? 32'd0 : mem_pc[rd_ptr];
  assign o_upd_pattern = o_empty ? 2'd0  : mem_pat[rd_ptr];
  assign o_upd_taken   = o_empty ? 1'b0  : mem_taken[rd_ptr];
  assign o_upd_target  = o_empty ? 32'd0 : mem_target[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= 32'd0;
      o_drop           <= 1'b0;
    end else begin
      o_redirect_valid <= bco_ok;
      if (bco_ok) o_redirect_pc <= i_bco_target;
      o_drop <= drop_next;
      if (i_flush) begin
        // A pop in this cycle has already been sampled by the predictor,
        // so clearing everything here still completes it.
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + (ADDR_W+1)'(1);
          2'b01:   count <= count - (ADDR_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (push) begin
        mem_pc[wr_ptr]     <= i_bco_pc;
        mem_pat[wr_ptr]    <= new_pat;
        mem_taken[wr_ptr]  <= i_bco_taken;
        mem_target[wr_ptr] <= i_bco_target;
      end
`ifdef BRU_BCO_COALESCE_EN
      if (coalesce) begin
        mem_pat[newest]    <= new_pat;
        mem_taken[newest]  <= i_bco_taken;
        mem_target[newest] <= i_bco_target;
      end
`endif
    end
  end

endmodule

// File: tb/tb_execute_bru_bco_ctrl.sv
module tb_execute_bru_bco_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_flush = 1'b0;
  logic        i_bco_valid = 1'b0;
  logic [31:0] i_bco_pc = 32'd0;
  logic [1:0]  i_bco_oldpattern = 2'd0;
  logic        i_bco_taken = 1'b0;
  logic [31:0] i_bco_target = 32'd0;
  logic        i_upd_ready = 1'b0;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;
  logic        o_upd_valid;
  logic [31:0] o_upd_pc;
  logic [1:0]  o_upd_pattern;
  logic        o_upd_taken;
  logic [31:0] o_upd_target;
  logic        o_full, o_empty, o_drop;

  execute_bru_bco_ctrl #(.DEPTH(DEPTH), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .i_flush(i_flush),
    .i_bco_valid(i_bco_valid), .i_bco_pc(i_bco_pc),
    .i_bco_oldpattern(i_bco_oldpattern), .i_bco_taken(i_bco_taken),
    .i_bco_target(i_bco_target),
    .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
    .o_upd_valid(o_upd_valid), .o_upd_pc(o_upd_pc),
    .o_upd_pattern(o_upd_pattern), .o_upd_taken(o_upd_taken),
    .o_upd_target(o_upd_target), .i_upd_ready(i_upd_ready),
    .o_full(o_full), .o_empty(o_empty), .o_drop(o_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [1:0]  pat;
    logic        taken;
    logic [31:0] tgt;
  } entry_t;

  entry_t      mq[$];
  logic        m_rv = 1'b0;
  logic [31:0] m_rpc = 32'd0;
  logic        m_drop = 1'b0;

  function automatic logic [1:0] ref_pat(input logic [1:0] old, input logic tk);
    int v;
    v = tk ? int'(old) + 1 : int'(old) - 1;
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  task automatic model_edge();
    bit     popping;
    bit     coal;
    int     sz;
    entry_t e;
    sz      = mq.size();
    popping = (sz > 0) && i_upd_ready;
    if (reset) begin
      mq.delete(); m_rv = 0; m_rpc = 0; m_drop = 0;
    end else if (i_flush) begin
      mq.delete(); m_rv = 0; m_drop = 0;
    end else begin
      coal = 0;
`ifdef BRU_BCO_COALESCE_EN
      if (i_bco_valid && sz >= 1 && mq[sz-1].pc == i_bco_pc && !(sz == 1 && popping))
        coal = 1;
`endif
      m_drop = 0;
      m_rv   = i_bco_valid;
      if (i_bco_valid) m_rpc = i_bco_target;
      e.pc = i_bco_pc; e.pat = ref_pat(i_bco_oldpattern, i_bco_taken);
      e.taken = i_bco_taken; e.tgt = i_bco_target;
      if (coal) begin
        mq[sz-1].pat = e.pat; mq[sz-1].taken = e.taken; mq[sz-1].tgt = e.tgt;
      end
      if (popping) void'(mq.pop_front());
      if (i_bco_valid && !coal) begin
        if (sz < DEPTH || popping) mq.push_back(e);
        else m_drop = 1;
      end
    end
  endtask

  task automatic check_model();
    bit ne;
    ne = mq.size() > 0;
    chk("m_redirect_valid", 32'(o_redirect_valid), 32'(m_rv));
    chk("m_redirect_pc", o_redirect_pc, m_rpc);
    chk("m_drop", 32'(o_drop), 32'(m_drop));
    chk("m_upd_valid", 32'(o_upd_valid), 32'(ne));
    chk("m_empty", 32'(o_empty), 32'(!ne));
    chk("m_full", 32'(o_full), 32'(mq.size() == DEPTH));
    chk("m_upd_pc", o_upd_pc, ne ? mq[0].pc : 32'd0);
    chk("m_upd_pattern", 32'(o_upd_pattern), ne ? 32'(mq[0].pat) : 32'd0);
    chk("m_upd_taken", 32'(o_upd_taken), ne ? 32'(mq[0].taken) : 32'd0);
    chk("m_upd_target", o_upd_target, ne ? mq[0].tgt : 32'd0);
  endtask

  // Drive at the negative edge, let one rising edge pass, check at the next negative edge.
  task automatic step(input logic rst, input logic fl, input logic v,
                      input logic [31:0] pc, input logic [1:0] old, input logic tk,
                      input logic [31:0] tgt, input logic rdy);
    reset = rst; i_flush = fl; i_bco_valid = v; i_bco_pc = pc;
    i_bco_oldpattern = old; i_bco_taken = tk; i_bco_target = tgt; i_upd_ready = rdy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0, rdy);
  endtask

  task automatic ovr(input logic [31:0] pc, input logic [1:0] old, input logic tk,
                     input logic [31:0] tgt, input logic rdy);
    step(1'b0, 1'b0, 1'b1, pc, old, tk, tgt, rdy);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic rst, fl, v; logic [31:0] pc; logic [1:0] old; logic tk; logic [31:0] tgt; logic rdy;
    logic e_rv; logic [31:0] e_rpc; logic e_uv; logic [31:0] e_upc; logic [1:0] e_pat;
    logic e_tk; logic [31:0] e_utgt; logic e_empty, e_full, e_drop;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1,0,0,32'h0,2'd0,0,32'h0,0,   0,32'h0,   0,32'h0,   2'd0,0,32'h0,   1,0,0};
    tbl[1] = '{0,0,1,32'h1000,2'd1,1,32'h2000,1, 1,32'h2000,1,32'h1000,2'd2,1,32'h2000,0,0,0};
    tbl[2] = '{0,0,0,32'h0,2'd0,0,32'h0,1,   0,32'h2000,0,32'h0,   2'd0,0,32'h0,   1,0,0};
    tbl[3] = '{0,0,1,32'h1010,2'd3,1,32'h3000,1, 1,32'h3000,1,32'h1010,2'd3,1,32'h3000,0,0,0};
    tbl[4] = '{0,0,1,32'h1020,2'd0,0,32'h1004,1, 1,32'h1004,1,32'h1020,2'd0,0,32'h1004,0,0,0};
    tbl[5] = '{0,0,0,32'h0,2'd0,0,32'h0,1,   0,32'h1004,0,32'h0,   2'd0,0,32'h0,   1,0,0};

    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].rst, tbl[i].fl, tbl[i].v, tbl[i].pc, tbl[i].old, tbl[i].tk, tbl[i].tgt, tbl[i].rdy);
      chk($sformatf("t%0d_redirect_valid", i), 32'(o_redirect_valid), 32'(tbl[i].e_rv));
      chk($sformatf("t%0d_redirect_pc", i), o_redirect_pc, tbl[i].e_rpc);
      chk($sformatf("t%0d_upd_valid", i), 32'(o_upd_valid), 32'(tbl[i].e_uv));
      chk($sformatf("t%0d_upd_pc", i), o_upd_pc, tbl[i].e_upc);
      chk($sformatf("t%0d_upd_pattern", i), 32'(o_upd_pattern), 32'(tbl[i].e_pat));
      chk($sformatf("t%0d_upd_taken", i), 32'(o_upd_taken), 32'(tbl[i].e_tk));
      chk($sformatf("t%0d_upd_target", i), o_upd_target, tbl[i].e_utgt);
      chk($sformatf("t%0d_empty", i), 32'(o_empty), 32'(tbl[i].e_empty));
      chk($sformatf("t%0d_full", i), 32'(o_full), 32'(tbl[i].e_full));
      chk($sformatf("t%0d_drop", i), 32'(o_drop), 32'(tbl[i].e_drop));
    end

    // Stalled: five overrides into a four-deep queue.
    for (int i = 0; i < 5; i++) begin
      ovr(32'h4000 + 32'(i*4), 2'd1, 1'b1, 32'h5000 + 32'(i*16), 1'b0);
      chk("s3_redirect_each", 32'(o_redirect_valid), 32'd1);
      chk("s3_redirect_pc_each", o_redirect_pc, 32'h5000 + 32'(i*16));
      chk("s3_full", 32'(o_full), (i >= 3) ? 32'd1 : 32'd0);
      chk("s3_drop", 32'(o_drop), (i == 4) ? 32'd1 : 32'd0);
    end
    idle(1'b0);
    chk("s3_drop_one_cycle", 32'(o_drop), 32'd0);
    idle(1'b0);
    chk("s3_head_stable", o_upd_pc, 32'h4000);
    for (int i = 0; i < 4; i++) begin
      chk("s3_drain_order", o_upd_pc, 32'h4000 + 32'(i*4));
      idle(1'b1);
    end
    chk("s3_empty_after", 32'(o_empty), 32'd1);

    // Full with simultaneous pop and push.
    for (int i = 0; i < 4; i++) ovr(32'h6000 + 32'(i*4), 2'd2, 1'b0, 32'h7000, 1'b0);
    chk("s4_full", 32'(o_full), 32'd1);
    ovr(32'h6100, 2'd2, 1'b1, 32'h7100, 1'b1);
    chk("s4_no_drop", 32'(o_drop), 32'd0);
    chk("s4_still_full", 32'(o_full), 32'd1);
    chk("s4_head_after", o_upd_pc, 32'h6004);
    idle(1'b1); chk("s4_order2", o_upd_pc, 32'h6008);
    idle(1'b1); chk("s4_order3", o_upd_pc, 32'h600c);
    idle(1'b1); chk("s4_last_new", o_upd_pc, 32'h6100);
    chk("s4_last_pattern", 32'(o_upd_pattern), 32'd3);
    idle(1'b1); chk("s4_empty", 32'(o_empty), 32'd1);

    // Flush with a same-cycle override.
    for (int i = 0; i < 3; i++) ovr(32'h8000 + 32'(i*4), 2'd1, 1'b0, 32'h8800, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h8100, 2'd1, 1'b1, 32'h8900, 1'b1);
    chk("s5_flush_no_redirect", 32'(o_redirect_valid), 32'd0);
    chk("s5_flush_no_drop", 32'(o_drop), 32'd0);
    chk("s5_flush_empty", 32'(o_empty), 32'd1);
    chk("s5_flush_no_upd", 32'(o_upd_valid), 32'd0);

    // Reset mid-drain.
    for (int i = 0; i < 3; i++) ovr(32'h9000 + 32'(i*4), 2'd2, 1'b1, 32'h9800, 1'b0);
    idle(1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h9100, 2'd2, 1'b1, 32'h9900, 1'b1);
    chk("s5_rst_redirect_valid", 32'(o_redirect_valid), 32'd0);
    chk("s5_rst_redirect_pc", o_redirect_pc, 32'd0);
    chk("s5_rst_upd_valid", 32'(o_upd_valid), 32'd0);
    chk("s5_rst_upd_pc", o_upd_pc, 32'd0);
    chk("s5_rst_upd_pattern", 32'(o_upd_pattern), 32'd0);
    chk("s5_rst_upd_taken", 32'(o_upd_taken), 32'd0);
    chk("s5_rst_upd_target", o_upd_target, 32'd0);
    chk("s5_rst_full", 32'(o_full), 32'd0);
    chk("s5_rst_drop", 32'(o_drop), 32'd0);
    chk("s5_rst_empty", 32'(o_empty), 32'd1);

    // Same PC twice while stalled.
    ovr(32'h3000, 2'd1, 1'b1, 32'h3100, 1'b0);
    ovr(32'h3000, 2'd2, 1'b0, 32'h3004, 1'b0);
`ifdef BRU_BCO_COALESCE_EN
    chk("s6_head_pattern", 32'(o_upd_pattern), 32'd1);
    chk("s6_head_taken", 32'(o_upd_taken), 32'd0);
    idle(1'b1);
    chk("s6_count_one", 32'(o_empty), 32'd1);
`else
    chk("s6_head_pattern", 32'(o_upd_pattern), 32'd2);
    chk("s6_head_taken", 32'(o_upd_taken), 32'd1);
    idle(1'b1);
    chk("s6_count_two", 32'(o_empty), 32'd0);
    chk("s6_second_pattern", 32'(o_upd_pattern), 32'd1);
    idle(1'b1);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rpc;
      rpc = 32'h100 + 32'($urandom_range(0, 2) * 4);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 1)), rpc, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
